// File: rtl/voice_playback_if.sv
// Purpose: groups the playback control, RAM read port and audio output signals.
//   slave  : seen by voice_playback (control/ram_data in; strobes, audio, status out)
//   master : seen by the controlling side and RAM model
// Signals: start, stop, ram_rd, ram_addr[ADDR_W], ram_data[WIDTH],
//          audio_out, audio_en, busy, done
interface voice_playback_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 7
) ();
  logic              start;
  logic              stop;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_data;
  logic              audio_out;
  logic              audio_en;
  logic              busy;
  logic              done;

  modport slave (
    input  start, stop, ram_data,
    output ram_rd, ram_addr, audio_out, audio_en, busy, done
  );

  modport master (
    output start, stop, ram_data,
    input  ram_rd, ram_addr, audio_out, audio_en, busy, done
  );
endinterface

// File: rtl/voice_playback.sv
// Purpose: replays DEPTH bytes from the sample RAM as a 1-bit MSB-first audio stream,
//   each bit held CLK_DIV cycles, with gapless prefetch of the following byte.
// Ports:
//   clk      : system clock
//   reset_L  : asynchronous active-low reset
//   bus      : voice_playback_if.slave (start/stop, RAM read port, audio_out/audio_en,
//              busy, done)
module voice_playback #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  voice_playback_if.slave  bus
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              pf_pend_q, pf_pend_d;   // next byte already requested
  logic              rd_prev_q;              // ram_data is valid this cycle
  logic              ram_rd_q, ram_rd_d;
  logic              audio_en_q, audio_en_d;
  logic              audio_out_q, audio_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pf_c;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      shreg_q     <= '0;
      hold_q      <= '0;
      bit_idx_q   <= '0;
      div_cnt_q   <= '0;
      pf_pend_q   <= 1'b0;
      rd_prev_q   <= 1'b0;
      ram_rd_q    <= 1'b0;
      audio_en_q  <= 1'b0;
      audio_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      bit_idx_q   <= bit_idx_d;
      div_cnt_q   <= div_cnt_d;
      pf_pend_q   <= pf_pend_d;
      rd_prev_q   <= ram_rd_q;
      ram_rd_q    <= ram_rd_d;
      audio_en_q  <= audio_en_d;
      audio_out_q <= audio_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    shreg_d   = shreg_q;
    hold_d    = hold_q;
    bit_idx_d = bit_idx_q;
    div_cnt_d = div_cnt_q;
    pf_pend_d = pf_pend_q;
    done_d    = 1'b0;
    pf_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          addr_d  = '0;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shreg_d   = bus.ram_data;
        bit_idx_d = '0;
        div_cnt_d = '0;
        pf_pend_d = 1'b0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (rd_prev_q) begin
          hold_d = bus.ram_data;
        end
        if (div_cnt_q == LAST_DIV) begin
          div_cnt_d = '0;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            if (pf_pend_q) begin
              // With a short divider the prefetched byte may arrive on this very edge.
              shreg_d   = rd_prev_q ? bus.ram_data : hold_q;
              pf_pend_d = 1'b0;
            end else begin
              state_d = IDLE;
              addr_d  = '0;
              done_d  = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            shreg_d   = shreg_q << 1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort takes priority over everything except being idle.
    if ((state_q != IDLE) && bus.stop) begin
      state_d   = IDLE;
      addr_d    = '0;
      bit_idx_d = '0;
      div_cnt_d = '0;
      pf_pend_d = 1'b0;
      done_d    = 1'b0;
    end

    // Request the next byte on the first cycle of the final bit of the current one.
    pf_c = (state_d == SHIFT) && (bit_idx_d == LAST_BIT) && (div_cnt_d == '0) &&
           !pf_pend_d && (addr_q != LAST_ADDR);
    if (pf_c) begin
      addr_d    = addr_q + ADDR_W'(1);
      pf_pend_d = 1'b1;
    end

    ram_rd_d    = (state_d == FETCH) || pf_c;
    audio_en_d  = (state_d == SHIFT);
    audio_out_d = audio_en_d & shreg_d[WIDTH-1];
    busy_d      = (state_d != IDLE);
  end

  assign bus.ram_rd    = ram_rd_q;
  assign bus.ram_addr  = addr_q;
  assign bus.audio_out = audio_out_q;
  assign bus.audio_en  = audio_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_voice_playback.sv
// Purpose: scoreboard bench for voice_playback (DEPTH=4, CLK_DIV=2, WIDTH=8).
module tb_voice_playback;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned RUN     = DEPTH * WIDTH * CLK_DIV;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  voice_playback_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  voice_playback #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .bus(bus)
  );

  // Sample RAM with one cycle of read latency.
  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.ram_rd) bus.ram_data <= mem[bus.ram_addr];
  end

  int checks = 0;
  int errors = 0;
  bit exp_bits[$];
  int exp_addr[$];
  int exp_run = RUN;
  bit exp_done_end = 1'b1;
  bit en_prev = 1'b0;
  int run_len = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reads RAM or emits an audio bit.
  always @(negedge clk) begin
    if (!reset_L) begin
      en_prev = 1'b0;
      run_len = 0;
    end else begin
      if (bus.ram_rd) begin
        check("ram_rd_expected", 32'(exp_addr.size() > 0), 32'd1);
        if (exp_addr.size() > 0) check("ram_addr", 32'(bus.ram_addr), 32'(exp_addr.pop_front()));
      end
      if (bus.audio_en) begin
        check("bit_expected", 32'(exp_bits.size() > 0), 32'd1);
        if (exp_bits.size() > 0) check("audio_bit", 32'(bus.audio_out), 32'(exp_bits.pop_front()));
        run_len++;
      end
      if (en_prev && !bus.audio_en) begin
        check("run_len", 32'(run_len), 32'(exp_run));
        check("done_at_end", 32'(bus.done), 32'(exp_done_end));
        run_len = 0;
      end else begin
        check("done_spurious", 32'(bus.done), 32'd0);
      end
      en_prev = bus.audio_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_run();
    for (int a = 0; a < int'(DEPTH); a++) begin
      exp_addr.push_back(a);
      for (int b = int'(WIDTH) - 1; b >= 0; b--)
        for (int c = 0; c < int'(CLK_DIV); c++) exp_bits.push_back(mem[a][b]);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (!bus.audio_en && n < 20) begin tick(); n++; end
    check(tag, 32'(bus.audio_en), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.done && n < 1000) begin tick(); n++; end
    check(tag, 32'(bus.done), 32'd1);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_bits_left"}, 32'(exp_bits.size()), 32'd0);
    check({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_audio_en"}, 32'(bus.audio_en), 32'd0);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_done"},     32'(bus.done),     32'd0);
    check({tag, "_ram_rd"},   32'(bus.ram_rd),   32'd0);
    check({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = WIDTH'(i);
    repeat (2) tick();
    check_idle("reset");
    reset_L = 1'b1;
    tick();

    // Reset asserted mid-SHIFT clears everything asynchronously.
    push_run();
    pulse_start();
    wait_en("rst_en_seen");
    repeat (5) tick();
    reset_L = 1'b0;
    #1;
    check_idle("midrst");
    exp_bits.delete();
    exp_addr.delete();
    tick();
    reset_L = 1'b1;
    repeat (3) tick();
    check_idle("after_rst");

    // Basic playback, RAM[i]=i, with start-to-audio latency.
    push_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("fetch_busy", 32'(bus.busy), 32'd1);
    check("fetch_rd", 32'(bus.ram_rd), 32'd1);
    check("fetch_addr", 32'(bus.ram_addr), 32'd0);
    check("fetch_en", 32'(bus.audio_en), 32'd0);
    tick();
    check("load_en", 32'(bus.audio_en), 32'd0);
    tick();
    check("shift_en", 32'(bus.audio_en), 32'd1);
    wait_done("done_basic");
    tick();
    check_empty("basic");
    check_idle("basic_end");

    // Patterned bytes, gapless across byte boundaries.
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h0F; mem[3] = 8'hF0;
    push_run();
    pulse_start();
    wait_done("done_pattern");
    tick();
    check_empty("pattern");

    // start while busy is ignored.
    push_run();
    pulse_start();
    wait_en("busy_en_seen");
    repeat (10) tick();
    pulse_start();
    wait_done("done_busy_start");
    tick();
    check_empty("busy_start");

    // stop at bit 3 of byte 1, then replay from address 0.
    push_run();
    exp_run = 16 + 7;
    exp_done_end = 1'b0;
    pulse_start();
    wait_en("stop_en_seen");
    repeat (22) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_idle("stop");
    exp_bits.delete();
    exp_addr.delete();
    repeat (4) tick();
    exp_run = RUN;
    exp_done_end = 1'b1;
    push_run();
    pulse_start();
    wait_done("done_replay");
    tick();
    check_empty("replay");

    // start and stop together in IDLE: start wins.
    push_run();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("start_wins_busy", 32'(bus.busy), 32'd1);
    wait_done("done_start_wins");
    tick();
    check_empty("start_wins");

    // start held high: back-to-back identical playbacks.
    push_run();
    push_run();
    bus.start = 1'b1;
    wait_done("done_b2b_1");
    tick();
    check("b2b_fetch_rd", 32'(bus.ram_rd), 32'd1);
    check("b2b_fetch_addr", 32'(bus.ram_addr), 32'd0);
    wait_done("done_b2b_2");
    bus.start = 1'b0;
    repeat (3) tick();
    check_empty("b2b");
    check_idle("b2b_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
